// File: rtl/sar_result_buffer.sv
// Back-end for sar_logic: captures conversion codes on soc, averages 1/2/4/8 samples,
// and queues the words in a first-word-fall-through FIFO with valid/ready output.
module sar_result_buffer #(
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             soc,
    input  logic [8:0]       result,
    input  logic [1:0]       avg_sel,
    input  logic             clr_ovf,
    output logic [8:0]       dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic          primed_q, primed_d;
    logic [11:0]   acc_q, acc_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          ovf_q, ovf_d;
    logic [8:0]    mem_q [DEPTH];
    logic [8:0]    mem_d [DEPTH];

    logic          sample, last, push, pop, empty, full;
    logic [1:0]    eff_sel;
    logic [2:0]    cnt_lim;
    logic [11:0]   sum;
    logic [8:0]    word;

    always_comb begin
        primed_d = primed_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        ovf_d    = ovf_q;
        mem_d    = mem_q;

        // First soc after reset has no finished conversion behind it.
        sample = soc & primed_q;
        if (soc) primed_d = 1'b1;

        eff_sel = (cnt_q == 3'd0) ? avg_sel : sel_q;
        case (eff_sel)
            2'd0:    cnt_lim = 3'd0;
            2'd1:    cnt_lim = 3'd1;
            2'd2:    cnt_lim = 3'd3;
            default: cnt_lim = 3'd7;
        endcase
        sum  = acc_q + {3'b000, result};
        last = (cnt_q == cnt_lim);
        word = 9'(sum >> eff_sel);
        push = sample & last;

        empty = (wptr_q == rptr_q);
        full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        pop   = ~empty & dout_ready;

        if (sample) begin
            if (cnt_q == 3'd0) sel_d = avg_sel;
            if (last) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 3'd1;
            end
        end

        // When full, a same-cycle pop frees the slot being written.
        if (push && (!full || pop)) begin
            mem_d[wptr_q[AW-1:0]] = word;
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) rptr_d = rptr_q + 1'b1;

        if (clr_ovf) ovf_d = 1'b0;
        if (push && full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            primed_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            primed_q <= primed_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

    assign dout       = mem_q[rptr_q[AW-1:0]];
    assign dout_valid = (wptr_q != rptr_q);
    assign fifo_level = LVL_W'(wptr_q - rptr_q);
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_sar_result_buffer.sv
// Directed bench for sar_result_buffer: per-cycle vector table plus drain sequences.
module tb_sar_result_buffer;
    logic       clock = 1'b0;
    logic       reset_n, soc, clr_ovf, dout_ready;
    logic [8:0] result;
    logic [1:0] avg_sel;
    logic [8:0] dout;
    logic       dout_valid, overflow;
    logic [2:0] fifo_level;

    int errors = 0;
    int checks = 0;

    sar_result_buffer #(.DEPTH(4), .LVL_W(3)) dut (
        .clock(clock), .reset_n(reset_n), .soc(soc), .result(result),
        .avg_sel(avg_sel), .clr_ovf(clr_ovf), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst_n, soc;
        logic [8:0] res;
        logic [1:0] sel;
        logic       clr, rdy;
        logic       cd;
        logic       e_vld;
        logic [8:0] e_dout;
        logic [2:0] e_lvl;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[80];
    int   n = 0;

    task automatic add(input logic rst_n, input logic s, input logic [8:0] res, input logic [1:0] sel,
                       input logic clr, input logic rdy, input logic cd, input logic ev,
                       input logic [8:0] ed, input logic [2:0] el, input logic eo);
        tbl[n].rst_n = rst_n; tbl[n].soc = s; tbl[n].res = res; tbl[n].sel = sel;
        tbl[n].clr = clr; tbl[n].rdy = rdy; tbl[n].cd = cd; tbl[n].e_vld = ev;
        tbl[n].e_dout = ed; tbl[n].e_lvl = el; tbl[n].e_ovf = eo;
        n++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            reset_n = tbl[i].rst_n; soc = tbl[i].soc; result = tbl[i].res;
            avg_sel = tbl[i].sel; clr_ovf = tbl[i].clr; dout_ready = tbl[i].rdy;
            tick();
            soc = 1'b0; clr_ovf = 1'b0; dout_ready = 1'b0; reset_n = 1'b1;
            chk("dout_valid", i, int'(dout_valid), int'(tbl[i].e_vld));
            chk("fifo_level", i, int'(fifo_level), int'(tbl[i].e_lvl));
            chk("overflow", i, int'(overflow), int'(tbl[i].e_ovf));
            if (tbl[i].cd || tbl[i].e_vld) chk("dout", i, int'(dout), int'(tbl[i].e_dout));
        end
    endtask

    task automatic drain(input int id, input logic [8:0] exp[$]);
        foreach (exp[k]) begin
            int budget = 0;
            while (!dout_valid && budget < 5) begin
                tick();
                budget++;
            end
            chk("drain_valid", id * 10 + k, int'(dout_valid), 1);
            chk("drain_dout", id * 10 + k, int'(dout), int'(exp[k]));
            dout_ready = 1'b1;
            tick();
            dout_ready = 1'b0;
        end
        chk("drain_empty", id, int'(dout_valid), 0);
    endtask

    int p1, p2, p3;

    initial begin
        reset_n = 1'b0; soc = 1'b0; result = '0; avg_sel = '0; clr_ovf = 1'b0; dout_ready = 1'b0;

        //   rst soc res     sel clr rdy cd vld dout    lvl ovf
        // priming and pass-through
        add(0, 0, 9'h000, 0, 0, 0, 1, 0, 9'h000, 0, 0);
        add(1, 1, 9'h1FF, 0, 0, 0, 1, 0, 9'h000, 0, 0);
        add(1, 1, 9'h0AA, 0, 0, 0, 1, 1, 9'h0AA, 1, 0);
        add(1, 0, 9'h000, 0, 0, 0, 1, 1, 9'h0AA, 1, 0);
        add(1, 1, 9'h155, 0, 0, 0, 1, 1, 9'h0AA, 2, 0);
        add(1, 1, 9'h001, 0, 0, 0, 1, 1, 9'h0AA, 3, 0);
        add(1, 0, 9'h000, 0, 0, 1, 1, 1, 9'h155, 2, 0);
        add(1, 0, 9'h000, 0, 0, 1, 1, 1, 9'h001, 1, 0);
        add(1, 0, 9'h000, 0, 0, 1, 0, 0, 9'h000, 0, 0);
        // average by 4, avg_sel change mid-window ignored
        add(1, 1, 9'h100, 2, 0, 0, 0, 0, 9'h000, 0, 0);
        add(1, 1, 9'h101, 2, 0, 0, 0, 0, 9'h000, 0, 0);
        add(1, 1, 9'h102, 0, 0, 0, 0, 0, 9'h000, 0, 0);
        add(1, 1, 9'h104, 0, 0, 0, 1, 1, 9'h101, 1, 0);
        add(1, 0, 9'h000, 0, 0, 1, 0, 0, 9'h000, 0, 0);
        // window of 2 latched, then single samples
        add(1, 1, 9'h010, 1, 0, 0, 0, 0, 9'h000, 0, 0);
        add(1, 1, 9'h020, 0, 0, 0, 1, 1, 9'h018, 1, 0);
        add(1, 1, 9'h033, 0, 0, 1, 1, 1, 9'h033, 1, 0);
        add(1, 1, 9'h044, 0, 0, 0, 1, 1, 9'h033, 2, 0);
        add(1, 0, 9'h000, 0, 0, 1, 1, 1, 9'h044, 1, 0);
        add(1, 0, 9'h000, 0, 0, 1, 0, 0, 9'h000, 0, 0);
        // empty with push and pop together
        add(1, 1, 9'h055, 0, 0, 1, 1, 1, 9'h055, 1, 0);
        add(1, 0, 9'h000, 0, 0, 1, 0, 0, 9'h000, 0, 0);
        // overflow, set wins over clear, then clear
        add(1, 1, 9'h001, 0, 0, 0, 1, 1, 9'h001, 1, 0);
        add(1, 1, 9'h002, 0, 0, 0, 1, 1, 9'h001, 2, 0);
        add(1, 1, 9'h003, 0, 0, 0, 1, 1, 9'h001, 3, 0);
        add(1, 1, 9'h004, 0, 0, 0, 1, 1, 9'h001, 4, 0);
        add(1, 1, 9'h005, 0, 0, 0, 1, 1, 9'h001, 4, 1);
        add(1, 0, 9'h000, 0, 0, 0, 1, 1, 9'h001, 4, 1);
        add(1, 1, 9'h006, 0, 1, 0, 1, 1, 9'h001, 4, 1);
        add(1, 0, 9'h000, 0, 1, 0, 1, 1, 9'h001, 4, 0);
        add(1, 0, 9'h000, 0, 0, 0, 1, 1, 9'h001, 4, 0);
        p1 = n;
        // refill, then full push with simultaneous pop
        add(1, 1, 9'h001, 0, 0, 0, 1, 1, 9'h001, 1, 0);
        add(1, 1, 9'h002, 0, 0, 0, 1, 1, 9'h001, 2, 0);
        add(1, 1, 9'h003, 0, 0, 0, 1, 1, 9'h001, 3, 0);
        add(1, 1, 9'h004, 0, 0, 0, 1, 1, 9'h001, 4, 0);
        add(1, 1, 9'h009, 0, 0, 1, 1, 1, 9'h002, 4, 0);
        p2 = n;
        // reset mid-window, priming again, no partial word
        add(1, 1, 9'h1F0, 3, 0, 0, 0, 0, 9'h000, 0, 0);
        add(1, 1, 9'h1F0, 3, 0, 0, 0, 0, 9'h000, 0, 0);
        add(1, 1, 9'h1F0, 3, 0, 0, 0, 0, 9'h000, 0, 0);
        add(1, 1, 9'h1F0, 3, 0, 0, 0, 0, 9'h000, 0, 0);
        add(1, 1, 9'h1F0, 3, 0, 0, 0, 0, 9'h000, 0, 0);
        add(0, 1, 9'h1F0, 3, 0, 0, 1, 0, 9'h000, 0, 0);
        add(1, 1, 9'h100, 0, 0, 0, 1, 0, 9'h000, 0, 0);
        add(1, 1, 9'h0AB, 0, 0, 0, 1, 1, 9'h0AB, 1, 0);
        add(1, 0, 9'h000, 0, 0, 1, 0, 0, 9'h000, 0, 0);
        add(1, 1, 9'h0CD, 3, 0, 0, 0, 0, 9'h000, 0, 0);
        add(1, 0, 9'h000, 0, 0, 0, 0, 0, 9'h000, 0, 0);
        add(1, 0, 9'h000, 0, 0, 0, 0, 0, 9'h000, 0, 0);
        p3 = n;

        run_rows(0, p1);
        drain(1, '{9'h001, 9'h002, 9'h003, 9'h004});
        run_rows(p1, p2);
        drain(2, '{9'h002, 9'h003, 9'h004, 9'h009});
        chk("overflow_after_full_pop", 0, int'(overflow), 0);
        run_rows(p2, p3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sar_result_buffer.md
# sar_result_buffer

Digital back-end stage directly downstream of `sar_logic`. Captures each completed 9-bit conversion code from `result`, using `soc` as the conversion-boundary strobe. Optionally averages 1/2/4/8 consecutive codes. Queues the averaged words in a small first-word-fall-through FIFO with a valid/ready handshake toward the system-side consumer.

## Interface
Parameters:
- `DEPTH`, 4: FIFO depth in words; power of two, 2..16.
- `LVL_W`, 3: width of `fifo_level`; must hold 0..DEPTH.

Ports:
- `clock`  in  1  single block clock, same clock as `sar_logic`.
- `reset_n`  in  1  synchronous, active-low reset; sampled on rising edge of `clock`.
- `soc`  in  1  start-of-conversion strobe from `sar_logic`, one cycle high per conversion.
- `result`  in  9  conversion code from `sar_logic`; holds the previous conversion's final code in the `soc` cycle.
- `avg_sel`  in  2  averaging select: 0→1, 1→2, 2→4, 3→8 samples per output word.
- `clr_ovf`  in  1  clears `overflow` sticky bit.
- `dout`  out  9  FIFO head word; valid only while `dout_valid`=1.
- `dout_valid`  out  1  FIFO non-empty.
- `dout_ready`  in  1  consumer accepts head word when `dout_valid`&&`dout_ready` at a rising edge.
- `fifo_level`  out  LVL_W  number of stored words.
- `overflow`  out  1  sticky flag: an averaged word was dropped because the FIFO was full.

## Operation
- Reset (reset_n=0 at edge): `dout`=0, `dout_valid`=0, `fifo_level`=0, `overflow`=0. FIFO pointers, accumulator, sample counter and `primed` are cleared.
- Priming: the first `soc` after reset carries no completed conversion. That sample is discarded and `primed` is set. Every later `soc` cycle is a valid sample of `result`.
- Window control:
  - The averaging length is latched from `avg_sel` at the first valid sample of each window.
  - Changes to `avg_sel` mid-window take effect at the next window.
- Accumulator: 12 bits (9 + 3), zero-extended adds; it cannot overflow. The sample counter is 3 bits.
- Window completion: on the last sample of a window (count = 2^sel − 1), word = (acc + result) >> sel, truncated toward zero, giving 9 bits. Accumulator and counter then reset to 0 at the same edge.
- sel=0: every valid `result` is pushed unchanged.
- FIFO: circular buffer, DEPTH entries; pointers are log2(DEPTH)+1 bits and wrap.
  - Push when a word completes.
  - Pop on `dout_valid`&&`dout_ready`.
- Full with push and no pop: the new word is dropped, `overflow` sets, and stored contents are unchanged.
- Full with push and pop in the same cycle: both occur, and the level stays at DEPTH.
- Empty with push and pop in the same cycle: pop is ignored (`dout_valid`=0), and the push is stored.
- `overflow`: stays set until `clr_ovf`=1. If a set event and `clr_ovf` coincide, the set wins.
- `soc` asserted on consecutive cycles: each cycle is treated as a separate sample. No upstream protection is required.

## Timing
- Capture: `result` is sampled at the rising edge that ends the `soc`=1 cycle.
- Latency: a completing sample at edge E gives `dout_valid`=1 and `dout`=word in the cycle after E (1 cycle), if the FIFO was empty.
- `dout` is driven directly from the head entry register. There is no output mux register stage beyond the FIFO storage.
- Holding rule: `dout` and `dout_valid` stay stable while `dout_valid`=1 and `dout_ready`=0.
- `fifo_level` and `overflow` update at the same edge as the push/pop that changes them.
- Reset mid-operation: at the reset edge all state clears, including any partial window and stored words. Priming applies again.

## Test plan
- Priming and pass-through:
  - Stimulus: reset, avg_sel=0, four `soc` pulses with `result`=0x1FF, 0x0AA, 0x155, 0x001, `dout_ready`=0.
  - Required: 0x1FF is discarded; FIFO holds 0x0AA, 0x155, 0x001; `fifo_level`=3; `dout`=0x0AA one cycle after the second `soc`.
- Averaging by 4:
  - Stimulus: avg_sel=2 after priming, samples 0x100, 0x101, 0x102, 0x104.
  - Required: one word (0x407>>2)=0x101 appears one cycle after the 4th sample; the three intermediate samples produce no `dout_valid`.
- avg_sel change mid-window:
  - Stimulus: avg_sel=1, one sample 0x010, then avg_sel=0, then sample 0x020.
  - Required: a single word 0x018 is pushed; the following samples are pushed individually.
- Overflow and clear (DEPTH=4):
  - Stimulus: `dout_ready`=0, push 5 words 1..5.
  - Required: FIFO holds 1..4, `overflow`=1, `fifo_level`=4. Then `clr_ovf` pulse gives `overflow`=0. Draining yields 1,2,3,4 in order.
- Full simultaneous push/pop:
  - Stimulus: FIFO full with 1..4; `dout_ready`=1 in the same cycle as push of 9.
  - Required: `dout` becomes 2, `fifo_level` stays 4, `overflow` stays 0, and later drain yields 2,3,4,9.
- Reset mid-window:
  - Stimulus: avg_sel=3, 5 samples, then reset_n=0 for one edge.
  - Required: all outputs 0. The next `soc` is discarded as priming, and no partial-window word is ever output.
